// File: rtl/alu_bist_if.sv
// ALU operand/result bus between the self-test controller and the ALU.
// The BIST is the master: it drives operands and op and samples the result.
interface alu_bist_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_out;

  modport master (
    output alu_a,
    output alu_b,
    output alu_op,
    input  alu_out
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_op,
    output alu_out
  );
endinterface

// File: rtl/alu_bist.sv
// Built-in self-test controller for the LC-3b ALU.
// Walks LFSR-generated operand pairs through ADD, AND and XOR, samples the ALU
// result after its pipeline latency, compares with an internal golden value,
// counts mismatches (saturating) and captures the first failing vector.
module alu_bist #(
  parameter int          WIDTH       = 16,
  parameter int          NUM_VECTORS = 256,
  parameter int          ALU_LAT     = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  alu_bist_if.master       alu,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [1:0]       first_err_op
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  localparam int         VW       = $clog2(NUM_VECTORS + 1);
  localparam logic [2:0] LAT_LAST = (ALU_LAT > 0) ? 3'(ALU_LAT - 1) : 3'd0;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [15:0]      lfsr;
  logic [VW-1:0]    vec_idx;
  logic [2:0]       wait_cnt;

  logic             start_run;
  logic             last_op;
  logic             last_vec;
  logic             wait_last;
  logic             mismatch;
  logic [WIDTH-1:0] golden;
  logic [15:0]      err_next;
  logic [15:0]      a_next;

  // One Fibonacci step of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Golden result, compare, and the small decode terms shared by both processes.
  always_comb begin
    golden = '0;
    case (alu.alu_op)
      OP_ADD:  golden = alu.alu_a + alu.alu_b;
      OP_AND:  golden = alu.alu_a & alu.alu_b;
      OP_XOR:  golden = alu.alu_a ^ alu.alu_b;
      default: golden = '0;
    endcase
    mismatch  = (alu.alu_out != golden);
    err_next  = err_count;
    if (mismatch && (err_count != 16'hFFFF))
      err_next = err_count + 16'd1;
    start_run = ((state == IDLE) || (state == DONE)) && start;
    last_op   = (alu.alu_op == OP_XOR);
    last_vec  = (vec_idx == VW'(NUM_VECTORS - 1));
    wait_last = (wait_cnt == LAT_LAST);
    // Next A is two steps past the current A, i.e. one step past B.
    a_next    = lfsr_step(lfsr_step(lfsr));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: ISSUE -> WAIT (ALU_LAT cycles) -> CHECK, looping per op.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = ISSUE;
      ISSUE:      next_state = (ALU_LAT == 0) ? CHECK : WAIT;
      WAIT:       if (wait_last) next_state = CHECK;
      CHECK:      next_state = (last_op && last_vec) ? DONE : ISSUE;
      default:    next_state = IDLE;
    endcase
  end

  // Datapath: operand generation, latency counter, error bookkeeping, status.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr         <= SEED;
      vec_idx      <= '0;
      wait_cnt     <= '0;
      alu.alu_a    <= '0;
      alu.alu_b    <= '0;
      alu.alu_op   <= OP_ADD;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      first_err_a  <= '0;
      first_err_b  <= '0;
      first_err_op <= OP_ADD;
    end else if (start_run) begin
      lfsr         <= SEED;
      vec_idx      <= '0;
      wait_cnt     <= '0;
      alu.alu_a    <= WIDTH'(SEED);
      alu.alu_b    <= WIDTH'(lfsr_step(SEED));
      alu.alu_op   <= OP_ADD;
      busy         <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      first_err_a  <= '0;
      first_err_b  <= '0;
      first_err_op <= OP_ADD;
    end else begin
      case (state)
        ISSUE: wait_cnt <= '0;
        WAIT:  wait_cnt <= wait_cnt + 3'd1;
        CHECK: begin
          err_count <= err_next;
          if (mismatch && (err_count == 16'd0)) begin
            first_err_a  <= alu.alu_a;
            first_err_b  <= alu.alu_b;
            first_err_op <= alu.alu_op;
          end
          if (!last_op) begin
            alu.alu_op <= alu.alu_op + 2'd1;
          end else if (last_vec) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == 16'd0);
          end else begin
            lfsr       <= a_next;
            alu.alu_a  <= WIDTH'(a_next);
            alu.alu_b  <= WIDTH'(lfsr_step(a_next));
            alu.alu_op <= OP_ADD;
            vec_idx    <= vec_idx + VW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Testbench for alu_bist: three golden-ALU instances (latency 0, 1, 2, four
// vectors each) with optional single-fault injection, plus a stubbed-zero ALU
// instance with one vector. Expectations come from a behavioural model.
module tb_alu_bist;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;

  logic        busyV [0:3];
  logic        doneV [0:3];
  logic        passV [0:3];
  logic [15:0] errV  [0:3];
  logic [15:0] aV    [0:3];
  logic [15:0] bV    [0:3];
  logic [1:0]  opV   [0:3];
  logic [15:0] faV   [0:3];
  logic [15:0] fbV   [0:3];
  logic [1:0]  fopV  [0:3];

  logic        injEn   = 1'b0;
  logic [15:0] injA    = '0;
  logic [15:0] injB    = '0;
  logic [15:0] injMask = '0;
  logic [1:0]  injOp   = '0;

  int          errors = 0;
  int          checks = 0;
  int          doneAt [0:3];
  logic [15:0] expA   [0:3];
  logic [15:0] expB   [0:3];

  always #5 clk = ~clk;

  // Reference LFSR: feedback is the parity of the tap positions 0,2,3,5.
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    logic fb;
    fb = ^(s & 16'h002D);
    return {fb, s[15:1]};
  endfunction

  // Reference ALU behaviour.
  function automatic logic [15:0] aluRef(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] op);
    int sum;
    sum = (int'(a) + int'(b)) % 65536;
    case (op)
      2'd0:    return 16'(sum);
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return 16'h0;
    endcase
  endfunction

  // Golden ALU models with pipeline depth g, driving BIST instances with ALU_LAT=g.
  for (genvar g = 0; g < 3; g++) begin : gLat
    alu_bist_if #(.WIDTH(16)) bus ();
    logic [15:0] res;
    logic [15:0] pipe [0:2];

    assign res = aluRef(bus.alu_a, bus.alu_b, bus.alu_op) ^
                 ((injEn && bus.alu_a == injA && bus.alu_b == injB && bus.alu_op == injOp)
                  ? injMask : 16'h0);

    // ALU result pipeline.
    always @(posedge clk) begin
      pipe[0] <= res;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    if (g == 0) begin : gComb
      assign bus.alu_out = res;
    end else begin : gReg
      assign bus.alu_out = pipe[g-1];
    end

    alu_bist #(.WIDTH(16), .NUM_VECTORS(4), .ALU_LAT(g), .SEED(16'hACE1)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .alu          (bus),
      .busy         (busyV[g]),
      .done         (doneV[g]),
      .pass         (passV[g]),
      .err_count    (errV[g]),
      .first_err_a  (faV[g]),
      .first_err_b  (fbV[g]),
      .first_err_op (fopV[g])
    );

    assign aV[g]  = bus.alu_a;
    assign bV[g]  = bus.alu_b;
    assign opV[g] = bus.alu_op;
  end

  alu_bist_if #(.WIDTH(16)) stubBus ();
  assign stubBus.alu_out = 16'h0;

  alu_bist #(.WIDTH(16), .NUM_VECTORS(1), .ALU_LAT(1), .SEED(16'hACE1)) stubDut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .alu          (stubBus),
    .busy         (busyV[3]),
    .done         (doneV[3]),
    .pass         (passV[3]),
    .err_count    (errV[3]),
    .first_err_a  (faV[3]),
    .first_err_b  (fbV[3]),
    .first_err_op (fopV[3])
  );

  assign aV[3]  = stubBus.alu_a;
  assign bV[3]  = stubBus.alu_b;
  assign opV[3] = stubBus.alu_op;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start, optionally pulse it again mid-run, track operands and done timing.
  task automatic applyStimulus(input bit midStart);
    int  midK;
    int  c;
    bit  allDone;
    for (int g = 0; g < 4; g++) doneAt[g] = -1;
    midK = $urandom_range(2, 8);
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (midStart && k == midK)     start = 1'b1;
      if (midStart && k == midK + 1) start = 1'b0;
      if (k == 1) begin
        checkOutput("busy_up", 64'(busyV[1]), 64'd1);
        checkOutput("done_clr", 64'(doneV[1]), 64'd0);
        checkOutput("first_vec", {aV[1], bV[1]}, 64'hACE15670);
      end
      if ((k - 1) % 3 == 0 && (k - 1) / 3 < 12) begin
        c = (k - 1) / 3;
        checkOutput($sformatf("ops[%0d]", c), {aV[1], bV[1], opV[1]},
                    {expA[c / 3], expB[c / 3], 2'(c % 3)});
      end
      allDone = 1'b1;
      for (int g = 0; g < 4; g++) begin
        if (doneV[g] && doneAt[g] < 0) doneAt[g] = k - 1;
        if (doneAt[g] < 0) allDone = 1'b0;
      end
      if (allDone) break;
    end
    start = 1'b0;
  endtask

  // Compare end-of-run status of every instance with the reference model.
  task automatic checkResults(input int expErr, input int iv, input int io);
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("run_len[%0d]", g), 64'(doneAt[g]), 64'(12 * (g + 2)));
      checkOutput($sformatf("err_count[%0d]", g), 64'(errV[g]), 64'(expErr));
      checkOutput($sformatf("pass[%0d]", g), 64'(passV[g]), 64'(expErr == 0));
      checkOutput($sformatf("done[%0d]", g), 64'(doneV[g]), 64'd1);
      if (expErr > 0)
        checkOutput($sformatf("first_err[%0d]", g), {faV[g], fbV[g], fopV[g]},
                    {expA[iv], expB[iv], 2'(io)});
      else
        checkOutput($sformatf("first_err[%0d]", g), {faV[g], fbV[g], fopV[g]}, 64'd0);
    end
    checkOutput("stub_len", 64'(doneAt[3]), 64'd9);
    checkOutput("stub_err", 64'(errV[3]), 64'd3);
    checkOutput("stub_pass", 64'(passV[3]), 64'd0);
    checkOutput("stub_first", {faV[3], fbV[3], fopV[3]}, {16'hACE1, 16'h5670, 2'b00});
  endtask

  // Every instance must show the reset values.
  task automatic checkReset(input string tag);
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("%s_ops[%0d]", tag, g), {aV[g], bV[g], opV[g]}, 64'd0);
      checkOutput($sformatf("%s_stat[%0d]", tag, g),
                  {busyV[g], doneV[g], passV[g], errV[g], fopV[g]}, 64'd0);
      checkOutput($sformatf("%s_first[%0d]", tag, g), {faV[g], fbV[g]}, 64'd0);
    end
  endtask

  initial begin
    int iv;
    int io;

    expA[0] = 16'hACE1;
    for (int v = 0; v < 4; v++) begin
      expB[v] = lfsrNext(expA[v]);
      if (v < 3) expA[v+1] = lfsrNext(expB[v]);
    end

    repeat (3) @(negedge clk);
    checkReset("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] golden run");
    applyStimulus(1'b0);
    checkResults(0, 0, 0);

    $display("[TB] restart from done with start pulsed mid-run");
    applyStimulus(1'b1);
    checkResults(0, 0, 0);

    for (int t = 0; t < 3; t++) begin
      iv      = $urandom_range(0, 3);
      io      = $urandom_range(0, 2);
      injA    = expA[iv];
      injB    = expB[iv];
      injOp   = 2'(io);
      injMask = 16'($urandom_range(1, 65535));
      injEn   = 1'b1;
      $display("[TB] fault on vector %0d op %0d mask 0x%0h", iv, io, injMask);
      applyStimulus(1'b0);
      checkResults(1, iv, io);
      injEn = 1'b0;
    end

    $display("[TB] reset mid-run");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(3, 20)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkReset("midrst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle_hold", {busyV[1], aV[1], doneV[1]}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test controller for the LC-3b ALU: the initiator side of the ALU operand/result interface. On `start` it generates pseudo-random operand pairs from an LFSR and drives each pair through ADD, AND and XOR. After the ALU's registered latency it samples the ALU result and compares it against an internally computed golden value. It counts mismatches, captures the first failing vector and reports pass/fail. It sits beside the ALU in the CPU and drives the ALU's operand and op inputs when a self-test is requested.

## Interface
- `WIDTH`, 16, operand/result width.
- `NUM_VECTORS`, 256, operand pairs per run (≥1); each pair is checked under 3 ops.
- `ALU_LAT`, 1, clock cycles from stable operands/op to valid `alu_out` (0..7).
- `SEED`, 16'hACE1, LFSR load value (nonzero).

Ports:
- Clock and reset: one clock, `clk`; reset is synchronous and active-high, `rst`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  run request, sampled in IDLE or DONE.
- `alu_a`  out  WIDTH  operand A to ALU.
- `alu_b`  out  WIDTH  operand B to ALU.
- `alu_op`  out  2  ALU op: ADD=2'b00, AND=2'b01, XOR=2'b10.
- `alu_out`  in  WIDTH  ALU result.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until next start or reset.
- `pass`  out  1  `done` and `err_count`==0.
- `err_count`  out  16  mismatches this run, saturating at 16'hFFFF.
- `first_err_a`, `first_err_b`  out  WIDTH  operands of first mismatch.
- `first_err_op`  out  2  op of first mismatch.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE + `start`=1 -> ISSUE. On this transition:
  - load LFSR with SEED and clear `err_count`, `first_err_*` and `done`;
  - set vector index to 0 and op to ADD.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. Step: fb = s[0]^s[2]^s[3]^s[5]; s = {fb, s[15:1]}.
- Per vector: A = current LFSR value, B = LFSR stepped once. After the XOR check, the LFSR steps twice, so the next A is the step after B.
- ISSUE (1 cycle): drive `alu_a`=A, `alu_b`=B, `alu_op`=op.
  - -> WAIT if ALU_LAT>0, else -> CHECK.
- WAIT: hold operands for ALU_LAT cycles, then -> CHECK.
- CHECK (1 cycle), operands still held: compare `alu_out` with golden.
  - Golden: ADD=(A+B) mod 2^WIDTH (carry discarded), AND=A&B, XOR=A^B.
  - On mismatch: `err_count`++ (saturating). If this is the first mismatch, latch A, B and op into `first_err_*`.
  - Next: op ADD->AND->XOR. After XOR, vector index++.
  - If index reaches NUM_VECTORS -> DONE, else -> ISSUE.
- DONE: `done`=1, `busy`=0, operands hold their last values.
- `start` while `busy` is ignored.
- `rst` at any time, including mid-run, returns the block to IDLE. Reset values:
  - `alu_a`=0, `alu_b`=0, `alu_op`=ADD;
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_*`=0;
  - LFSR=SEED.

## Timing
- `start` sampled high at edge n: `busy`=1 and first operands valid after edge n.
- Each check takes ALU_LAT+2 cycles.
- Run length is NUM_VECTORS·3·(ALU_LAT+2) cycles from the first ISSUE to the DONE entry.
- `done` and `pass` become valid in the same cycle and are registered.
- `alu_out` is sampled in the final cycle of each check. The ALU must present a result that depends only on operands stable for ALU_LAT edges.
- All outputs are registered. No combinational path from `alu_out` to any output.

## Test plan
- Golden ALU, ALU_LAT=1, NUM_VECTORS=4: pulse `start`. Required:
  - first vector A=0xACE1, B=0x5670;
  - expected ADD 0x0351 (wrap), AND 0x0460, XOR 0xFA91;
  - `done` exactly 36 cycles after the first ISSUE, `err_count`=0, `pass`=1.
- ALU stubbed to output 0, NUM_VECTORS=1: required `err_count`=3, `pass`=0, `first_err_a`=0xACE1, `first_err_b`=0x5670, `first_err_op`=ADD.
- ALU_LAT=0 and ALU_LAT=2 with golden ALU, NUM_VECTORS=4: `done` after 24 and 48 cycles respectively, `pass`=1. Sampling exactly at latency must not produce spurious errors.
- `start` pulsed mid-run -> ignored, run length unchanged. `rst` asserted mid-run -> next cycle all outputs equal reset values and state is IDLE.
- Restart from DONE -> `done` clears, the operand sequence repeats from A=0xACE1, and the results are identical to the first run.
